jk_seq_driver: RTL and testbench
================================

Name: jk_seq_driver

Overview:
- Synthesizable driver/checker for the team's `jk` flip-flop (ports clk, J, K, Q, Qn).
- Takes a target Q bit sequence and derives the J/K excitation needed to make the flop's Q follow that sequence, one bit per clock. It is the inverse of the JK characteristic equation.
- Also samples the flop's Q back and counts mismatches, so JK-based designs can be self-checked in hardware and in benches.

Parameters:
- LEN, 8: number of pattern bits per run (≥1).
- CNT_W, $clog2(LEN+2): width of err_cnt.
- DC_MODE, 0: resolution of excitation don't-cares. 0 = X→0 (set/reset style). 1 = X→1 (toggle style).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a run; sampled only in IDLE.
- pattern  input  LEN  target Q sequence; bit 0 applied first; captured on accepted start.
- q_in  input  1  Q from the driven flop.
- j  output  1  registered J to flop.
- k  output  1  registered K to flop.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse at end of run.
- err_cnt  output  CNT_W  mismatches in the last/current run.
- pass  output  1  err_cnt==0 at done; held until next accepted start.

Behaviour:
- Reset (rst_n=0 at rising edge): state=IDLE, j=0, k=0, busy=0, done=0, err_cnt=0, pass=0, pattern register and index = 0. Reset mid-run aborts immediately; no done pulse.
- States: IDLE, CLR, DRIVE, DRAIN.
- IDLE: start=1 at edge E0 → latch pattern, err_cnt=0, pass=0, busy=1, j=0, k=1 (forced clear, independent of unknown initial Q), go to CLR.
- CLR (edge E1, flop now Q=0): prev=0; output j/k for bit 0; idx=1; go to DRIVE.
- DRIVE: at each edge, compare q_in with the expected value of the previous cycle's applied bit (clear=0 first, then pattern[0..]); increment err_cnt on mismatch; output j/k for pattern[idx] from prev=pattern[idx-1]. After bit LEN-1 is issued, go to DRAIN with j=0, k=0 (hold).
- DRAIN: checks the remaining applied bits. Drive j=0, k=0 throughout.
- Timing: bit i is presented on j/k after E(i+1), applied by the flop at E(i+2), and checked at E(i+3). Clear is checked at E2.
- End of run: last check at E(LEN+2); at that edge busy←0, done←1 for one cycle, pass←(final err_cnt==0), state→IDLE. Start-to-done latency is LEN+2 cycles.
- Excitation, prev→next gives j,k (d = DC_MODE): 0→0: 0,d. 0→1: 1,d. 1→0: d,1. 1→1: d,0.
- err_cnt range is 0..LEN+1 (clear check included); no wrap is possible.
- start while busy is ignored. start in the same cycle as done is not accepted; it is accepted on the following edge in IDLE.
- q_in is compared with ===-equivalent semantics in benches. In RTL, any non-matching value counts as an error.
- j/k never change except at clock edges. Neither output is derived combinationally from q_in.

Test Plan:
- LEN=8, DC_MODE=0, pattern=8'b1011_0010 with real `jk` flop → j/k bit-sequence matches the excitation table; Q follows 0,0,1,0,0,1,1,0,1; done at E10; err_cnt=0, pass=1.
- DC_MODE=1, pattern=8'b0101_0101 → every transition issues j=1,k=1 (toggle); Q alternates; err_cnt=0.
- q_in forced to 1 for one cycle at E5 (pattern all zeros) → err_cnt=1, pass=0. Forcing q_in=1 permanently → err_cnt=9.
- rst_n=0 at E4 mid-run → next cycle all outputs at reset values, no done. A fresh start afterwards completes normally with pass=1.
- start held high across done plus back-to-back runs → second run's E0 is the cycle after done. err_cnt clears on the new start; pass from the first run holds until then.
- Initial flop Q=X at start → CLR forces Q=0 by E1; run passes. The X only appears on q_in before E2 and is never compared.

Source files
------------

// File: rtl/jk_seq_driver.sv
// jk_seq_driver: derives J/K excitation so a jk flop's Q follows a target pattern, and counts Q mismatches.
module jk_seq_driver #(
  parameter int LEN = 8,
  parameter int CNT_W = $clog2(LEN + 2),
  parameter int DC_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN-1:0]   pattern,
  input  logic             q_in,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic             pass
);
  typedef enum logic [1:0] {IDLE, CLR, DRIVE, DRAIN} state_t;
  localparam logic D = (DC_MODE != 0);
  state_t state, state_n;
  logic [LEN-1:0] pat, pat_n;
  logic [CNT_W-1:0] idx, idx_n, err_n;
  logic ea, ea_n, eb, eb_n, j_n, k_n, busy_n, done_n, pass_n, miss;
  // ea: bit currently on j/k (next Q); eb: bit the flop applied last edge (checked now)
  function automatic logic [1:0] exc(input logic p, input logic n);
    return p ? {D, ~n} : {n, D};
  endfunction
  assign miss = q_in != eb;
  always_comb begin
    state_n = state;
    pat_n = pat;
    idx_n = idx;
    err_n = err_cnt;
    ea_n = ea;
    eb_n = eb;
    j_n = j;
    k_n = k;
    busy_n = busy;
    done_n = 1'b0;
    pass_n = pass;
    case (state)
      IDLE: if (start) begin
        pat_n = pattern;
        err_n = '0;
        pass_n = 1'b0;
        busy_n = 1'b1;
        {j_n, k_n} = 2'b01;
        ea_n = 1'b0;
        idx_n = '0;
        state_n = CLR;
      end
      CLR: begin
        {j_n, k_n} = exc(1'b0, pat[0]);
        ea_n = pat[0];
        eb_n = ea;
        pat_n = pat >> 1;
        idx_n = CNT_W'(1);
        state_n = DRIVE;
      end
      DRIVE: begin
        err_n = err_cnt + CNT_W'(miss);
        eb_n = ea;
        if (idx == CNT_W'(LEN)) begin
          {j_n, k_n} = 2'b00;
          state_n = DRAIN;
        end else begin
          {j_n, k_n} = exc(ea, pat[0]);
          ea_n = pat[0];
          pat_n = pat >> 1;
          idx_n = idx + CNT_W'(1);
        end
      end
      default: begin
        err_n = err_cnt + CNT_W'(miss);
        busy_n = 1'b0;
        done_n = 1'b1;
        pass_n = err_n == '0;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pat <= '0;
      idx <= '0;
      err_cnt <= '0;
      ea <= 1'b0;
      eb <= 1'b0;
      j <= 1'b0;
      k <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      state <= state_n;
      pat <= pat_n;
      idx <= idx_n;
      err_cnt <= err_n;
      ea <= ea_n;
      eb <= eb_n;
      j <= j_n;
      k <= k_n;
      busy <= busy_n;
      done <= done_n;
      pass <= pass_n;
    end
  end
endmodule

// File: tb/tb_jk_seq_driver.sv
// tb_jk_seq_driver: scoreboard bench driving two drivers (DC_MODE 0 and 1), each with its own jk flop model.
module tb_jk_seq_driver;
  logic clk = 1'b0;
  logic rst_n, start, ovr;
  logic [7:0] pattern;
  logic [1:0] jv, kv, bv, dv, pv, q, qi;
  logic [3:0] ev [2];
  logic [7:0] sb [$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  jk_seq_driver #(.LEN(8), .DC_MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
    .q_in(qi[0]), .j(jv[0]), .k(kv[0]), .busy(bv[0]), .done(dv[0]), .err_cnt(ev[0]), .pass(pv[0]));
  jk_seq_driver #(.LEN(8), .DC_MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
    .q_in(qi[1]), .j(jv[1]), .k(kv[1]), .busy(bv[1]), .done(dv[1]), .err_cnt(ev[1]), .pass(pv[1]));
  // Behavioural jk flops; Q powers up as X so the forced clear is exercised
  always @(posedge clk) begin
    q[0] <= (jv[0] & kv[0]) ? ~q[0] : jv[0] ? 1'b1 : kv[0] ? 1'b0 : q[0];
    q[1] <= (jv[1] & kv[1]) ? ~q[1] : jv[1] ? 1'b1 : kv[1] ? 1'b0 : q[1];
  end
  assign qi = ovr ? 2'b11 : q;
  function automatic logic [1:0] exc(input logic p, input logic n, input logic d);
    case ({p, n})
      2'b00: return {1'b0, d};
      2'b01: return {1'b1, d};
      2'b10: return {d, 1'b1};
      default: return {d, 1'b0};
    endcase
  endfunction
  task automatic run_pat(input logic [7:0] p, input logic [15:0] mask, input bit hold, input string name);
    int exp_err;
    logic prv;
    logic [3:0] nib [2];
    logic [7:0] got, want;
    exp_err = 0;
    for (int c = 2; c <= 10; c++)
      if (mask[c] && (((c == 2) ? 1'b0 : p[c-3]) == 1'b0)) exp_err++;
    for (int t = 0; t <= 10; t++) begin
      for (int m = 0; m < 2; m++) begin
        if (t == 0) nib[m] = 4'b0110;
        else if (t <= 8) begin
          prv = (t == 1) ? 1'b0 : p[t-2];
          nib[m] = {exc(prv, p[t-1], m[0]), 2'b10};
        end else if (t == 9) nib[m] = 4'b0010;
        else nib[m] = 4'b0001;
      end
      sb.push_back({nib[1], nib[0]});
    end
    pattern = p;
    start = 1'b1;
    ovr = mask[0];
    for (int t = 0; t <= 10; t++) begin
      @(posedge clk);
      #1;
      if (!hold) begin
        start = 1'b0;
        pattern = ~p;
      end
      ovr = mask[t+1];
      got = {jv[1], kv[1], bv[1], dv[1], jv[0], kv[0], bv[0], dv[0]};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s jkbd t=%0d got %b want %b", name, t, got, want);
      end
      if (t == 0) for (int m = 0; m < 2; m++) begin
        checks++;
        if (ev[m] !== 4'd0 || pv[m] !== 1'b0) begin
          errors++;
          $display("FAIL %s clear_on_start dut%0d err_cnt=%0d pass=%b want 0 0", name, m, ev[m], pv[m]);
        end
      end
    end
    ovr = 1'b0;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (ev[m] !== 4'(exp_err) || pv[m] !== (exp_err == 0)) begin
        errors++;
        $display("FAIL %s result dut%0d err_cnt=%0d pass=%b want %0d %b", name, m, ev[m], pv[m], exp_err, exp_err == 0);
      end
    end
  endtask
  task automatic check_idle(input string name);
    checks++;
    if ({jv, kv, bv, dv, pv} !== 10'd0 || ev[0] !== 4'd0 || ev[1] !== 4'd0) begin
      errors++;
      $display("FAIL %s outputs jkbdp=%b err=%0d/%0d want all 0", name, {jv, kv, bv, dv, pv}, ev[0], ev[1]);
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    ovr = 1'b0;
    pattern = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
  endtask
  task automatic test_nominal();
    run_pat(8'b1011_0010, 16'h0000, 1'b0, "nominal");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pv !== 2'b11 || dv !== 2'b00 || ev[0] !== 4'd0) begin
      errors++;
      $display("FAIL pass_hold pass=%b done=%b err=%0d want 11 00 0", pv, dv, ev[0]);
    end
  endtask
  task automatic test_toggle();
    run_pat(8'b0101_0101, 16'h0000, 1'b0, "toggle");
    run_pat(8'b1111_1111, 16'h0000, 1'b0, "ones");
  endtask
  task automatic test_errors();
    run_pat(8'h00, 16'h0020, 1'b0, "inject_e5");
    run_pat(8'h00, 16'hFFFF, 1'b0, "stuck_one");
    run_pat(8'b1100_1010, 16'h0114, 1'b0, "inject_mixed");
  endtask
  task automatic test_abort();
    bit seen;
    pattern = 8'hA5;
    start = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_idle("abort");
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (dv !== 2'b00) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_done done seen=1 want 0");
    end
    run_pat(8'b0110_1001, 16'h0000, 1'b0, "after_abort");
  endtask
  task automatic test_back_to_back();
    run_pat(8'h3C, 16'h0040, 1'b1, "b2b_first");
    run_pat(8'hC3, 16'h0000, 1'b1, "b2b_second");
    start = 1'b0;
    run_pat(8'h81, 16'h0000, 1'b0, "b2b_third");
  endtask
  initial begin
    test_reset();
    test_nominal();
    test_toggle();
    test_errors();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
